// File: rtl/pe_pkg.sv
// rtl/pe_pkg.sv - shared constants and arithmetic helpers for the complex MAC processing element
package pe_pkg;

  localparam int WORD_LEN_DEF  = 24;
  localparam int ACC_DEPTH_DEF = 16;
  localparam int OUT_LEN_DEF   = 32;

  // Working width for round_sat; comfortably wider than any accumulator in use.
  localparam int RS_W = 128;

  typedef struct packed {
    logic signed [RS_W-1:0] val;
    logic                   clip;
  } rs_t;

  // Accumulator width: full product, one bit for the complex add, log2 of the term count.
  function automatic int acc_len(input int word_len, input int acc_depth);
    return 2 * word_len + $clog2(acc_depth) + 1;
  endfunction

  // Round half up, arithmetic shift right, then clip to a signed out_len-bit range.
  function automatic rs_t round_sat(input logic signed [RS_W-1:0] sum, input int shift,
                                    input int out_len);
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    rs_t res;
    one = RS_W'(1);
    r   = sum;
    if (shift > 0) begin
      r = (sum + (one <<< (shift - 1))) >>> shift;
    end
    hi       = (one <<< (out_len - 1)) - one;
    lo       = -(one <<< (out_len - 1));
    res.val  = r;
    res.clip = 1'b0;
    if (r > hi) begin
      res.val  = hi;
      res.clip = 1'b1;
    end else if (r < lo) begin
      res.val  = lo;
      res.clip = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmul_pipe.sv
// rtl/cmul_pipe.sv - registered complex multiplier with optional conjugation of the second operand
module cmul_pipe
  import pe_pkg::*;
#(
  parameter int WORD_LEN = WORD_LEN_DEF,
  // Must exceed 2*WORD_LEN so the complex add/subtract cannot overflow.
  parameter int P_LEN    = 2 * WORD_LEN_DEF + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       conj,
  input  logic                       valid_in,
  input  logic signed [WORD_LEN-1:0] a_r,
  input  logic signed [WORD_LEN-1:0] a_i,
  input  logic signed [WORD_LEN-1:0] b_r,
  input  logic signed [WORD_LEN-1:0] b_i,
  output logic signed [P_LEN-1:0]    p_r,
  output logic signed [P_LEN-1:0]    p_i,
  output logic                       p_valid
);

  localparam int PW  = 2 * WORD_LEN;
  localparam int EXT = P_LEN - PW;

  logic signed [PW-1:0]    rr, ii, ir, ri;
  logic signed [P_LEN-1:0] rr_x, ii_x, ir_x, ri_x;
  logic signed [P_LEN-1:0] p_r_d, p_r_q, p_i_d, p_i_q;
  logic                    p_valid_d, p_valid_q;

  assign rr = a_r * b_r;
  assign ii = a_i * b_i;
  assign ir = a_i * b_r;
  assign ri = a_r * b_i;

  assign rr_x = {{EXT{rr[PW-1]}}, rr};
  assign ii_x = {{EXT{ii[PW-1]}}, ii};
  assign ir_x = {{EXT{ir[PW-1]}}, ir};
  assign ri_x = {{EXT{ri[PW-1]}}, ri};

  // Next product stage: load on en, conj flips the sign of the imaginary weight terms.
  always_comb begin
    p_r_d     = p_r_q;
    p_i_d     = p_i_q;
    p_valid_d = p_valid_q;
    if (en) begin
      p_valid_d = valid_in;
      if (conj) begin
        p_r_d = rr_x + ii_x;
        p_i_d = ir_x - ri_x;
      end else begin
        p_r_d = rr_x - ii_x;
        p_i_d = ir_x + ri_x;
      end
    end
    if (clr) begin
      p_valid_d = 1'b0;
    end
  end

  // Product stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r_q     <= '0;
      p_i_q     <= '0;
      p_valid_q <= 1'b0;
    end else begin
      p_r_q     <= p_r_d;
      p_i_q     <= p_i_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p_r     = p_r_q;
  assign p_i     = p_i_q;
  assign p_valid = p_valid_q;

endmodule

// File: rtl/cmac_pe_acc.sv
// rtl/cmac_pe_acc.sv - systolic complex multiply-accumulate PE with rounded, saturated handshake output
module cmac_pe_acc
  import pe_pkg::*;
#(
  parameter int WORD_LEN  = WORD_LEN_DEF,
  parameter int ACC_DEPTH = ACC_DEPTH_DEF,
  parameter int ACC_LEN   = acc_len(WORD_LEN, ACC_DEPTH),
  parameter int OUT_LEN   = OUT_LEN_DEF,
  parameter int SHIFT     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       conj,
  input  logic                       valid,
  input  logic signed [WORD_LEN-1:0] din_R,
  input  logic signed [WORD_LEN-1:0] din_I,
  input  logic signed [WORD_LEN-1:0] w_R,
  input  logic signed [WORD_LEN-1:0] w_I,
  output logic signed [WORD_LEN-1:0] din_R_nxt,
  output logic signed [WORD_LEN-1:0] din_I_nxt,
  output logic signed [WORD_LEN-1:0] w_R_nxt,
  output logic signed [WORD_LEN-1:0] w_I_nxt,
  output logic                       valid_nxt,
  output logic signed [OUT_LEN-1:0]  dout_R,
  output logic signed [OUT_LEN-1:0]  dout_I,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       sat_flag,
  output logic                       ovf_err
);

  localparam int CNT_W = $clog2(ACC_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_DEPTH - 1);

  logic signed [ACC_LEN-1:0]  p_r, p_i;
  logic                       p_valid;

  logic signed [WORD_LEN-1:0] din_r_nxt_d, din_r_nxt_q, din_i_nxt_d, din_i_nxt_q;
  logic signed [WORD_LEN-1:0] w_r_nxt_d, w_r_nxt_q, w_i_nxt_d, w_i_nxt_q;
  logic                       valid_nxt_d, valid_nxt_q;

  logic signed [ACC_LEN-1:0]  acc_r_d, acc_r_q, acc_i_d, acc_i_q;
  logic [CNT_W-1:0]           cnt_d, cnt_q;
  logic signed [OUT_LEN-1:0]  dout_r_d, dout_r_q, dout_i_d, dout_i_q;
  logic                       dout_valid_d, dout_valid_q;
  logic                       sat_d, sat_q, ovf_d, ovf_q;

  logic signed [ACC_LEN-1:0]  sum_r, sum_i;
  rs_t                        rs_r, rs_i;
  logic                       done;
  logic                       unused_rs_hi;

  cmul_pipe #(
    .WORD_LEN (WORD_LEN),
    .P_LEN    (ACC_LEN)
  ) u_cmul (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .conj     (conj),
    .valid_in (valid),
    .a_r      (din_R),
    .a_i      (din_I),
    .b_r      (w_R),
    .b_i      (w_I),
    .p_r      (p_r),
    .p_i      (p_i),
    .p_valid  (p_valid)
  );

  // Neighbour pass-through: follows the inputs on every enabled edge regardless of valid.
  always_comb begin
    din_r_nxt_d = din_r_nxt_q;
    din_i_nxt_d = din_i_nxt_q;
    w_r_nxt_d   = w_r_nxt_q;
    w_i_nxt_d   = w_i_nxt_q;
    valid_nxt_d = valid_nxt_q;
    if (en) begin
      din_r_nxt_d = din_R;
      din_i_nxt_d = din_I;
      w_r_nxt_d   = w_R;
      w_i_nxt_d   = w_I;
      valid_nxt_d = valid;
    end
  end

  // Completed sum including the final term, then rounded and clipped per component.
  always_comb begin
    sum_r = acc_r_q + p_r;
    sum_i = acc_i_q + p_i;
    rs_r  = round_sat({{(RS_W - ACC_LEN){sum_r[ACC_LEN-1]}}, sum_r}, SHIFT, OUT_LEN);
    rs_i  = round_sat({{(RS_W - ACC_LEN){sum_i[ACC_LEN-1]}}, sum_i}, SHIFT, OUT_LEN);
  end

  // After clipping only the low OUT_LEN bits carry information.
  assign unused_rs_hi = ^{rs_r.val[RS_W-1:OUT_LEN], rs_i.val[RS_W-1:OUT_LEN]};

  assign done = en && p_valid && (cnt_q == CNT_LAST);

  // Accumulate, count terms, and manage the output holding register; clr overrides all.
  always_comb begin
    acc_r_d      = acc_r_q;
    acc_i_d      = acc_i_q;
    cnt_d        = cnt_q;
    dout_r_d     = dout_r_q;
    dout_i_d     = dout_i_q;
    dout_valid_d = dout_valid_q;
    sat_d        = sat_q;
    ovf_d        = ovf_q;

    if (en && p_valid) begin
      // The first term of a dot product loads directly, so back-to-back sums need no gap.
      if (cnt_q == '0) begin
        acc_r_d = p_r;
        acc_i_d = p_i;
      end else begin
        acc_r_d = sum_r;
        acc_i_d = sum_i;
      end
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end

    if (done) begin
      if (rs_r.clip || rs_i.clip) begin
        sat_d = 1'b1;
      end
      if (!dout_valid_q || dout_ready) begin
        dout_r_d     = rs_r.val[OUT_LEN-1:0];
        dout_i_d     = rs_i.val[OUT_LEN-1:0];
        dout_valid_d = 1'b1;
      end else begin
        // Holding register still occupied: keep the older result and flag the loss.
        ovf_d = 1'b1;
      end
    end

    if (clr) begin
      acc_r_d      = '0;
      acc_i_d      = '0;
      cnt_d        = '0;
      dout_r_d     = '0;
      dout_i_d     = '0;
      dout_valid_d = 1'b0;
      sat_d        = 1'b0;
      ovf_d        = 1'b0;
    end
  end

  // State registers for pass-through, accumulator, counter and output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_r_nxt_q  <= '0;
      din_i_nxt_q  <= '0;
      w_r_nxt_q    <= '0;
      w_i_nxt_q    <= '0;
      valid_nxt_q  <= 1'b0;
      acc_r_q      <= '0;
      acc_i_q      <= '0;
      cnt_q        <= '0;
      dout_r_q     <= '0;
      dout_i_q     <= '0;
      dout_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      din_r_nxt_q  <= din_r_nxt_d;
      din_i_nxt_q  <= din_i_nxt_d;
      w_r_nxt_q    <= w_r_nxt_d;
      w_i_nxt_q    <= w_i_nxt_d;
      valid_nxt_q  <= valid_nxt_d;
      acc_r_q      <= acc_r_d;
      acc_i_q      <= acc_i_d;
      cnt_q        <= cnt_d;
      dout_r_q     <= dout_r_d;
      dout_i_q     <= dout_i_d;
      dout_valid_q <= dout_valid_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
    end
  end

  assign din_R_nxt  = din_r_nxt_q;
  assign din_I_nxt  = din_i_nxt_q;
  assign w_R_nxt    = w_r_nxt_q;
  assign w_I_nxt    = w_i_nxt_q;
  assign valid_nxt  = valid_nxt_q;
  assign dout_R     = dout_r_q;
  assign dout_I     = dout_i_q;
  assign dout_valid = dout_valid_q;
  assign sat_flag   = sat_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_cmac_pe_acc.sv
// tb/tb_cmac_pe_acc.sv - scoreboard bench for cmac_pe_acc across plain, saturating and rounding builds
module tb_cmac_pe_acc;

  localparam int WL = 24;
  localparam int AD = 4;
  localparam int AL = 2 * WL + $clog2(AD) + 1;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst_n, en, clr, conj, valid, dout_ready;
  logic signed [WL-1:0] din_R, din_I, w_R, w_I;

  logic signed [WL-1:0] a_dr_n, a_di_n, a_wr_n, a_wi_n;
  logic signed [WL-1:0] s_dr_n, s_di_n, s_wr_n, s_wi_n;
  logic signed [WL-1:0] r_dr_n, r_di_n, r_wr_n, r_wi_n;
  logic                 a_v_n, s_v_n, r_v_n;
  logic signed [AL-1:0] a_dout_R, a_dout_I, r_dout_R, r_dout_I;
  logic signed [SL-1:0] s_dout_R, s_dout_I;
  logic                 a_dv, s_dv, r_dv, a_sat, s_sat, r_sat, a_ovf, s_ovf, r_ovf;

  always #5 clk = ~clk;

  cmac_pe_acc #(.WORD_LEN(WL), .ACC_DEPTH(AD), .OUT_LEN(AL), .SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .conj(conj), .valid(valid),
    .din_R(din_R), .din_I(din_I), .w_R(w_R), .w_I(w_I),
    .din_R_nxt(a_dr_n), .din_I_nxt(a_di_n), .w_R_nxt(a_wr_n), .w_I_nxt(a_wi_n),
    .valid_nxt(a_v_n), .dout_R(a_dout_R), .dout_I(a_dout_I), .dout_valid(a_dv),
    .dout_ready(dout_ready), .sat_flag(a_sat), .ovf_err(a_ovf));

  cmac_pe_acc #(.WORD_LEN(WL), .ACC_DEPTH(AD), .OUT_LEN(SL), .SHIFT(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .conj(conj), .valid(valid),
    .din_R(din_R), .din_I(din_I), .w_R(w_R), .w_I(w_I),
    .din_R_nxt(s_dr_n), .din_I_nxt(s_di_n), .w_R_nxt(s_wr_n), .w_I_nxt(s_wi_n),
    .valid_nxt(s_v_n), .dout_R(s_dout_R), .dout_I(s_dout_I), .dout_valid(s_dv),
    .dout_ready(dout_ready), .sat_flag(s_sat), .ovf_err(s_ovf));

  cmac_pe_acc #(.WORD_LEN(WL), .ACC_DEPTH(AD), .OUT_LEN(AL), .SHIFT(2)) dut_r (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .conj(conj), .valid(valid),
    .din_R(din_R), .din_I(din_I), .w_R(w_R), .w_I(w_I),
    .din_R_nxt(r_dr_n), .din_I_nxt(r_di_n), .w_R_nxt(r_wr_n), .w_I_nxt(r_wi_n),
    .valid_nxt(r_v_n), .dout_R(r_dout_R), .dout_I(r_dout_I), .dout_valid(r_dv),
    .dout_ready(dout_ready), .sat_flag(r_sat), .ovf_err(r_ovf));

  typedef struct {
    longint ar, ai, sr, si, rr, ri;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_res(input longint ar, input longint ai, input longint sr,
                            input longint si, input longint rr, input longint ri);
    exp_t e;
    e.ar = ar; e.ai = ai; e.sr = sr; e.si = si; e.rr = rr; e.ri = ri;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic term(input int dr, input int di, input int wr, input int wi, input logic cj);
    din_R = WL'(dr);
    din_I = WL'(di);
    w_R   = WL'(wr);
    w_I   = WL'(wi);
    conj  = cj;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
  endtask

  // Monitor: every accepted result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && a_dv && dout_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got dout_R=%0d with nothing pending", a_dout_R);
      end else begin
        mon_e = sbq.pop_front();
        chk("a_dout_R", a_dout_R, mon_e.ar);
        chk("a_dout_I", a_dout_I, mon_e.ai);
        chk("s_dout_R", s_dout_R, mon_e.sr);
        chk("s_dout_I", s_dout_I, mon_e.si);
        chk("r_dout_R", r_dout_R, mon_e.rr);
        chk("r_dout_I", r_dout_I, mon_e.ri);
        chk("s_valid_aligned", s_dv, 1);
        chk("r_valid_aligned", r_dv, 1);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; conj = 1'b0; valid = 1'b0; dout_ready = 1'b1;
    din_R = '0; din_I = '0; w_R = '0; w_I = '0;
    idle(2);
    chk("rst_dout_valid", a_dv, 0);
    chk("rst_dout_R", a_dout_R, 0);
    chk("rst_din_R_nxt", a_dr_n, 0);
    chk("rst_valid_nxt", a_v_n, 0);
    chk("rst_sat", a_sat, 0);
    chk("rst_ovf", a_ovf, 0);
    rst_n = 1'b1;
    idle(1);

    // (1+2j)(3+4j) x4 = -20+40j, with latency and pass-through checks.
    expect_res(-20, 40, -20, 40, -5, 10);
    repeat (4) term(1, 2, 3, 4, 1'b0);
    chk("pass_din_R_nxt", a_dr_n, 1);
    chk("pass_w_I_nxt", a_wi_n, 4);
    chk("pass_valid_nxt", a_v_n, 1);
    chk("lat_cycle1_not_valid", a_dv, 0);
    idle(1);
    chk("lat_cycle2_valid", a_dv, 1);
    chk("pass_valid_nxt_low", a_v_n, 0);
    idle(2);

    // Conjugate: (1+2j)(3-4j) x4 = 44+8j.
    expect_res(44, 8, 44, 8, 11, 2);
    repeat (4) term(1, 2, 3, 4, 1'b1);
    idle(3);

    // Positive saturation in the 8-bit build, then clr.
    expect_res(400, 0, 127, 0, 100, 0);
    repeat (4) term(100, 0, 1, 0, 1'b0);
    idle(3);
    chk("s_sat_pos", s_sat, 1);
    chk("a_sat_none", a_sat, 0);
    pulse_clr();
    chk("s_sat_after_clr", s_sat, 0);

    // Negative saturation.
    expect_res(-400, 0, -128, 0, -100, 0);
    repeat (4) term(-100, 0, 1, 0, 1'b0);
    idle(3);
    chk("s_sat_neg", s_sat, 1);
    pulse_clr();

    // Rounding: sums 6 and -6.
    expect_res(6, -6, 6, -6, 2, -1);
    repeat (2) term(1, -1, 1, 0, 1'b0);
    repeat (2) term(2, -2, 1, 0, 1'b0);
    idle(3);

    // Rounding: sum 5.
    expect_res(5, 5, 5, 5, 1, 1);
    repeat (3) term(1, 1, 1, 0, 1'b0);
    term(2, 2, 1, 0, 1'b0);
    idle(3);

    // Backpressure across two completions: second result dropped.
    dout_ready = 1'b0;
    expect_res(-20, 40, -20, 40, -5, 10);
    repeat (4) term(1, 2, 3, 4, 1'b0);
    repeat (4) term(1, 2, 3, 4, 1'b1);
    idle(3);
    chk("bp_ovf_set", a_ovf, 1);
    chk("bp_held_R", a_dout_R, -20);
    chk("bp_held_valid", a_dv, 1);
    dout_ready = 1'b1;
    idle(2);
    chk("bp_drained", a_dv, 0);
    pulse_clr();
    chk("ovf_after_clr", a_ovf, 0);

    // Ready returns in the second completion cycle: second result replaces the first.
    dout_ready = 1'b0;
    expect_res(-20, 40, -20, 40, -5, 10);
    repeat (4) term(1, 2, 3, 4, 1'b0);
    idle(3);
    expect_res(44, 8, 44, 8, 11, 2);
    repeat (4) term(1, 2, 3, 4, 1'b1);
    dout_ready = 1'b1;
    idle(3);
    chk("replace_no_ovf", a_ovf, 0);
    chk("replace_drained", a_dv, 0);

    // Three-cycle en stall between terms 2 and 3; inputs wiggle while frozen.
    expect_res(-20, 40, -20, 40, -5, 10);
    repeat (2) term(1, 2, 3, 4, 1'b0);
    en = 1'b0;
    valid = 1'b1;
    din_R = WL'(77); din_I = WL'(-5); w_R = WL'(9); w_I = WL'(-9);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("stall_din_R_nxt", a_dr_n, 1);
      chk("stall_w_R_nxt", a_wr_n, 3);
    end
    valid = 1'b0;
    en = 1'b1;
    repeat (2) term(1, 2, 3, 4, 1'b0);
    idle(3);

    // Reset after two terms, then a clean dot product.
    repeat (2) term(1, 2, 3, 4, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_dout_R", a_dout_R, 0);
    chk("mid_rst_s_dout_I", s_dout_I, 0);
    chk("mid_rst_din_R_nxt", a_dr_n, 0);
    chk("mid_rst_valid_nxt", a_v_n, 0);
    chk("mid_rst_dout_valid", a_dv, 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    expect_res(-20, 40, -20, 40, -5, 10);
    repeat (4) term(1, 2, 3, 4, 1'b0);
    idle(3);

    for (int i = 0; i < 50 && sbq.size() != 0; i++) idle(1);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
